// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and the memory-operation decode
// used by the data-memory stage.
package y86_pkg;

  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_op_t;

  typedef enum logic {
    ADDR_VALE = 1'b0,
    ADDR_VALA = 1'b1
  } addr_src_t;

  typedef enum logic {
    DATA_VALA = 1'b0,
    DATA_VALP = 1'b1
  } data_src_t;

  typedef struct packed {
    mem_op_t   op;
    addr_src_t addr_src;
    data_src_t data_src;
  } mem_decode_t;

  // Stack pops (ret, popq) address memory through valA; call stores the return address.
  function automatic mem_decode_t decode_mem_op(input logic [3:0] icode);
    mem_decode_t d;
    d.op       = MEM_NONE;
    d.addr_src = ADDR_VALE;
    d.data_src = DATA_VALA;
    case (icode)
      ICODE_RMMOVQ, ICODE_PUSHQ: d.op = MEM_WRITE;
      ICODE_CALL: begin
        d.op       = MEM_WRITE;
        d.data_src = DATA_VALP;
      end
      ICODE_MRMOVQ: d.op = MEM_READ;
      ICODE_RET, ICODE_POPQ: begin
        d.op       = MEM_READ;
        d.addr_src = ADDR_VALA;
      end
      default: d.op = MEM_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 64-bit word RAM with synchronous write and registered read.
// No reset: contents and the read register survive a controller reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Y86-64 data-memory stage: decodes the memory operation, checks alignment and
// range, and performs the access after LATENCY wait states with a response pulse.
module data_memory_ctrl
  import y86_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] valM,
  output logic        dmem_error
);

  localparam int          ADDR_W     = $clog2(DEPTH_WORDS);
  localparam logic [64:0] BYTE_LIMIT = 65'(DEPTH_WORDS) << 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  mem_op_t           op_q;
  logic              err_q;
  logic [ADDR_W-1:0] idx_q;
  logic [63:0]       wdata_q;
  logic              valm_from_ram;

  mem_decode_t dec;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_bad;
  logic        access_now;
  logic        ram_we;
  logic        ram_re;
  logic [63:0] ram_rdata;

  always_comb begin
    dec       = decode_mem_op(icode);
    req_addr  = (dec.addr_src == ADDR_VALA) ? valA : valE;
    req_wdata = (dec.data_src == DATA_VALP) ? valP : valA;
    req_bad   = (dec.op != MEM_NONE) &&
                ((req_addr[2:0] != 3'b000) || ({1'b0, req_addr} >= BYTE_LIMIT));
  end

  assign access_now = (state == S_BUSY) && (cnt == 4'd0);
  assign ram_we     = access_now && !err_q && (op_q == MEM_WRITE);
  assign ram_re     = access_now && !err_q && (op_q == MEM_READ);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // The RAM read register only changes on reads, so it can drive valM directly
  // until an erroneous read or a reset forces the output to zero.
  assign valM = valm_from_ram ? ram_rdata : 64'd0;

  // Non-access and faulted requests pass through BUSY with cnt=0, which gives
  // them their one idle cycle before the response without touching the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      op_q          <= MEM_NONE;
      err_q         <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= 64'd0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      valm_from_ram <= 1'b0;
      dmem_error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= dec.op;
            err_q     <= req_bad;
            idx_q     <= req_addr[3 +: ADDR_W];
            wdata_q   <= req_wdata;
            cnt       <= ((dec.op == MEM_NONE) || req_bad) ? 4'd0 : 4'(LATENCY);
            req_ready <= 1'b0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= err_q;
            if (err_q) begin
              dmem_error <= 1'b1;
            end
            if (op_q == MEM_READ) begin
              valm_from_ram <= !err_q;
            end
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised data-memory stage for the Y86-64 processor, replacing the fixed single-cycle memory block. Decodes the memory operation from `icode`, forms the address, checks alignment and range, and performs the access after a configurable number of wait states. A valid/ready request and a one-cycle response pulse let the pipelined core stall on slow memory. Errors are reported per transaction and latched in a sticky status flag.

## Interface
- `DEPTH_WORDS`, default 1024: number of 64-bit words; must be a power of 2 and at least 2.
- `LATENCY`, default 1: extra wait cycles per memory access; range 0..15.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: block can accept a request; high only in IDLE.
- `icode` input, 4 bits: instruction code.
- `valE` input, 64 bits: computed address for rmmovq, mrmovq, call and pushq.
- `valA` input, 64 bits: store data, or the stack address for ret and popq.
- `valP` input, 64 bits: return address stored by call.
- `resp_valid` output, 1 bit: one-cycle completion pulse.
- `resp_err` output, 1 bit: error flag for this response; valid only while `resp_valid` is high.
- `valM` output, 64 bits: read data.
- `dmem_error` output, 1 bit: sticky error flag; cleared only by reset.

## Operation
- **Decode** (sampled at the accepting edge):
  - icode 4 (rmmovq), write: M[valE] = valA.
  - icode A (pushq), write: M[valE] = valA.
  - icode 8 (call), write: M[valE] = valP.
  - icode 5 (mrmovq), read: valM = M[valE].
  - icode 9 (ret), read: valM = M[valA].
  - icode B (popq), read: valM = M[valA].
  - Any other icode: no memory access.
- **Addressing:** addresses are byte addresses. Word index = addr[3 +: $clog2(DEPTH_WORDS)].
- **Error conditions:** an access is in error if addr[2:0] != 0, or if addr >= DEPTH_WORDS*8. The range compare is done in 65 bits so it cannot overflow.
- **Erroneous access:** no write, no read, `valM` is forced to 0, `resp_err` = 1, and `dmem_error` is set.
- **FSM states:** IDLE, BUSY, RESP.
  - IDLE: `req_ready` = 1. On `req_valid`, latch the operation, address and write data.
    - Non-access or erroneous request: go to RESP.
    - Valid access: go to BUSY with cnt = LATENCY.
  - BUSY: if cnt != 0, decrement cnt. If cnt == 0, perform the read or write on this edge and go to RESP.
  - RESP: `resp_valid` = 1 for exactly one cycle, then return to IDLE. `req_ready` = 0.
- **valM update:** `valM` changes only on a successful read (to the read data) or an erroneous read (to 0). It holds its value across writes and non-access requests.
- `req_valid` is ignored while `req_ready` = 0; requests are never queued.
- **Reset (any state):** state goes to IDLE, any pending access is dropped (a write not yet performed never happens), and memory contents are preserved.
- **Reset values:** `req_ready` = 1, `resp_valid` = 0, `resp_err` = 0, `valM` = 0, `dmem_error` = 0. Memory array is not reset.

## Timing
- Valid access accepted at edge t: access occurs at edge t+LATENCY+1, and `resp_valid` is high in the cycle after that edge.
- Non-access or erroneous request accepted at edge t: `resp_valid` is high in the cycle after edge t+1.
- Throughput: one transaction per LATENCY+3 cycles for accesses, and per 3 cycles otherwise.
- `valM` and `resp_err` are registered and stable while `resp_valid` is high.

## Structure
- **Shared package `y86_pkg`:**
  - icode constants: ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ.
  - `mem_op_t` enum: MEM_NONE, MEM_READ, MEM_WRITE.
  - Decode function mapping icode to operation and address source.
- FSM state enum is local to this block.
- **Sub-module `dmem_array`:** single-port synchronous RAM, parameter DEPTH_WORDS, with write enable and a registered read. It has no reset.

## Test plan
Settings for all scenarios: LATENCY=2, DEPTH_WORDS=1024.
- **Store then load:** rmmovq with valE=0x10, valA=0xDEADBEEF. `resp_valid` rises 3 edges after acceptance with `resp_err`=0. A following mrmovq with valE=0x10 returns `valM`=0xDEADBEEF.
- **Call then return:** call with valE=0x1F8, valP=0x123, then ret with valA=0x1F8. Response gives `valM`=0x123. A pushq/popq pair at 0x100 with data 0x55 gives `valM`=0x55.
- **Misaligned read:** mrmovq with valE=0x14. Response 1 edge after acceptance, `resp_err`=1, `valM`=0. `dmem_error` stays 1 through later good transactions until reset.
- **Range check:** mrmovq with valE=0x2000 gives an error. mrmovq with valE=0x1FF8 succeeds. valE=0xFFFFFFFFFFFFFFF8 gives an error with no wraparound.
- **Non-access and held request:** nop (icode 1) gets a response 1 edge after acceptance with `valM` unchanged. `req_valid` held high through BUSY is accepted only once `req_ready` returns high.
- **Reset mid-write:** write 7 to 0x40. Then pushq with valE=0x40, valA=5, and pulse `rst_n` low during BUSY. After reset, mrmovq 0x40 returns 7 and `dmem_error`=0.
